nes_pad_poller: RTL and testbench

NES_PAD_POLLER -- requirements
Module: nes_pad_poller

---
 rtl/nes_pad_poller_if.sv | 25 ++
 rtl/nes_pad_poller.sv | 84 ++++++++
 tb/tb_nes_pad_poller.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/nes_pad_poller_if.sv
// nes_pad_poller_if: pad-side bus of the NES/SNES poller.
//   poll_req  scan request from the host
//   pad_data  serial data from each pad, active-low
//   latch     shared latch strobe to the pads, active-high
//   pad_clk   shared pad clock, idles high
//   buttons   held button state, active-high, pad p bit k at p*BITS_PER_PAD+k
//   pressed   newly-pressed flags, same indexing
//   valid     one-cycle pulse when buttons/pressed update
//   state     current FSM state code
// The master modport is the poller, the slave modport is the host/pad side.
interface nes_pad_poller_if #(
  parameter int NUM_PADS = 2,
  parameter int BITS_PER_PAD = 8
);
  logic poll_req;
  logic [NUM_PADS-1:0] pad_data;
  logic latch;
  logic pad_clk;
  logic [NUM_PADS*BITS_PER_PAD-1:0] buttons;
  logic [NUM_PADS*BITS_PER_PAD-1:0] pressed;
  logic valid;
  logic [2:0] state;
  modport master (input poll_req, pad_data, output latch, pad_clk, buttons, pressed, valid, state);
  modport slave (output poll_req, pad_data, input latch, pad_clk, buttons, pressed, valid, state);
endinterface

// File: rtl/nes_pad_poller.sv
// nes_pad_poller: periodically latches and shifts in NUM_PADS serial game pads in parallel.
//   clk_10MHz  the only clock, rising edge
//   reset      asynchronous active-high reset
//   bus        nes_pad_poller_if master: poll_req/pad_data in; latch/pad_clk/buttons/pressed/valid/state out
// Optional feature: define NES_PAD_EDGE_EN to build the newly-pressed edge detector;
// without it pressed is tied to 0.
module nes_pad_poller #(
  parameter int NUM_PADS = 2,
  parameter int BITS_PER_PAD = 8,
  parameter int CLK_DIV = 30,
  parameter int POLL_PERIOD = 166666
) (
  input logic clk_10MHz,
  input logic reset,
  nes_pad_poller_if.master bus
);
  localparam int W = NUM_PADS * BITS_PER_PAD;
  localparam int PW = $clog2(2 * CLK_DIV + 1);
  localparam int BW = BITS_PER_PAD > 1 ? $clog2(BITS_PER_PAD) : 1;
  localparam int IW = $clog2(POLL_PERIOD + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, LATCH = 3'd1, CLK_LOW = 3'd2, CLK_HIGH = 3'd3, DONE = 3'd4} state_t;
  state_t cur, nxt;
  logic [PW-1:0] phase;
  logic [BW-1:0] bit_idx;
  logic [IW-1:0] idle_cnt;
  logic [W-1:0] shadow, buttons;
  logic valid, phase_end, start, last_bit, sample;
  always_ff @(posedge clk_10MHz or posedge reset)
    if (reset) cur <= IDLE;
    else cur <= nxt;
  always_comb begin
    phase_end = phase == PW'(cur == LATCH ? 2 * CLK_DIV - 1 : CLK_DIV - 1);
    start = bus.poll_req || idle_cnt == IW'(POLL_PERIOD - 1);
    last_bit = bit_idx == BW'(BITS_PER_PAD - 1);
    sample = phase_end && (cur == LATCH || cur == CLK_HIGH);
    nxt = cur;
    bus.latch = 1'b0;
    bus.pad_clk = 1'b1;
    case (cur)
      IDLE: nxt = start ? LATCH : IDLE;
      LATCH: begin
        bus.latch = 1'b1;
        nxt = phase_end ? (last_bit ? DONE : CLK_LOW) : LATCH;
      end
      CLK_LOW: begin
        bus.pad_clk = 1'b0;
        nxt = phase_end ? CLK_HIGH : CLK_LOW;
      end
      CLK_HIGH: nxt = phase_end ? (last_bit ? DONE : CLK_LOW) : CLK_HIGH;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // bit_idx is 0 during LATCH, so last_bit there is only true for one-bit pads
  always_ff @(posedge clk_10MHz or posedge reset)
    if (reset) begin
      phase <= '0;
      bit_idx <= '0;
      idle_cnt <= '0;
      shadow <= '0;
      buttons <= '0;
      valid <= 1'b0;
    end else begin
      phase <= (cur == IDLE || cur == DONE || phase_end) ? '0 : phase + 1'b1;
      idle_cnt <= (cur == IDLE && !start) ? idle_cnt + 1'b1 : '0;
      bit_idx <= cur == IDLE ? '0 : (sample && !last_bit) ? bit_idx + 1'b1 : bit_idx;
      if (sample)
        for (int p = 0; p < NUM_PADS; p++) shadow[p * BITS_PER_PAD + int'(bit_idx)] <= ~bus.pad_data[p];
      if (cur == DONE) buttons <= shadow;
      valid <= cur == DONE;
    end
  assign bus.buttons = buttons;
  assign bus.valid = valid;
  assign bus.state = cur;
`ifdef NES_PAD_EDGE_EN
  logic [W-1:0] pressed;
  always_ff @(posedge clk_10MHz or posedge reset)
    if (reset) pressed <= '0;
    else pressed <= cur == DONE ? shadow & ~buttons : '0;
  assign bus.pressed = pressed;
`else
  assign bus.pressed = '0;
`endif
endmodule

// File: tb/tb_nes_pad_poller.sv
// tb_nes_pad_poller: directed/randomized bench with a shift-register pad model and scan timing reference.
module tb_nes_pad_poller;
  localparam int CLK_DIV = 30;
  localparam int POLL = 1000;
  localparam int LAT_N = 2 * CLK_DIV;
  localparam int PULSES = 7;
  localparam int SCAN_LEN = 2 * CLK_DIV + 7 * 2 * CLK_DIV + 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int idle_n, lat_n, pulses, busy_n;
  bit got;
  logic [15:0] prev_b = '0;
  logic [7:0] mask0 = '0, mask1 = '0;
  logic [2:0] pidx = '0;
  logic [15:0] nb;
  int busy16 = 0, pulses16 = 0, last_busy16 = 0, last_pulses16 = 0, scans16 = 0;
  logic [15:0] last_buttons16 = '0;
  logic prev_clk16 = 1'b1;
  nes_pad_poller_if #(.NUM_PADS(2), .BITS_PER_PAD(8)) bus ();
  nes_pad_poller_if #(.NUM_PADS(1), .BITS_PER_PAD(16)) bus16 ();
  nes_pad_poller #(.NUM_PADS(2), .BITS_PER_PAD(8), .CLK_DIV(CLK_DIV), .POLL_PERIOD(POLL)) dut (
    .clk_10MHz(clk), .reset(reset), .bus(bus));
  nes_pad_poller #(.NUM_PADS(1), .BITS_PER_PAD(16), .CLK_DIV(CLK_DIV), .POLL_PERIOD(POLL)) dut16 (
    .clk_10MHz(clk), .reset(reset), .bus(bus16));
  always #50 clk = ~clk;
  // pad model: 4021-style shift register, bit 0 visible while latched, one shift per rising pad_clk
  always @(posedge bus.latch or posedge bus.pad_clk)
    if (bus.latch) pidx = 3'd0;
    else if (pidx != 3'd7) pidx = pidx + 3'd1;
  always_comb bus.pad_data = {~mask1[pidx], ~mask0[pidx]};
  // observer for the 16-bit instance: every pad bit held low (all pressed)
  always @(negedge clk)
    if (reset) begin
      busy16 = 0;
      pulses16 = 0;
      prev_clk16 = 1'b1;
    end else begin
      if (bus16.state != 3'd0) busy16++;
      if (prev_clk16 && !bus16.pad_clk) pulses16++;
      prev_clk16 = bus16.pad_clk;
      if (bus16.valid) begin
        last_busy16 = busy16;
        last_pulses16 = pulses16;
        last_buttons16 = bus16.buttons;
        scans16++;
        busy16 = 0;
        pulses16 = 0;
      end
    end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // samples once per cycle until a valid that follows a scan; poke>0 pulses poll_req at that scan cycle
  task automatic wait_valid(input int poke);
    bit busy_seen = 0;
    logic prev_clk = bus.pad_clk;
    idle_n = 0;
    lat_n = 0;
    pulses = 0;
    busy_n = 0;
    got = 0;
    for (int i = 0; i < 5000; i++) begin
      if (bus.state != 3'd0) begin
        busy_seen = 1;
        busy_n++;
      end else if (!busy_seen) idle_n++;
      if (bus.latch) lat_n++;
      if (prev_clk && !bus.pad_clk) pulses++;
      prev_clk = bus.pad_clk;
      if (bus.state == 3'd4) check("buttons_in_scan", bus.buttons, prev_b);
      if (poke > 0 && busy_n == poke && bus.state != 3'd0) check("poke_state", bus.state, 3);
      bus.poll_req = poke > 0 && busy_n == poke && bus.state != 3'd0;
      if (bus.valid && busy_seen) begin
        got = 1;
        break;
      end
      tick();
    end
    bus.poll_req = 1'b0;
    check("valid_timeout", 32'(got), 1);
  endtask
  task automatic scan(input logic [15:0] exp_b, input int exp_idle, input int poke);
    logic [15:0] exp_p;
    wait_valid(poke);
`ifdef NES_PAD_EDGE_EN
    exp_p = exp_b & ~prev_b;
`else
    exp_p = '0;
`endif
    if (exp_idle >= 0) check("idle_cycles", 32'(idle_n), 32'(exp_idle));
    check("latch_cycles", 32'(lat_n), LAT_N);
    check("clk_pulses", 32'(pulses), PULSES);
    check("scan_len", 32'(busy_n), SCAN_LEN);
    check("buttons", 32'(bus.buttons), 32'(exp_b));
    check("pressed", 32'(bus.pressed), 32'(exp_p));
    tick();
    check("valid_pulse", 32'(bus.valid), 0);
    check("pressed_clr", 32'(bus.pressed), 0);
    check("buttons_hold", 32'(bus.buttons), 32'(exp_b));
    prev_b = exp_b;
  endtask
  task automatic poll_start();
    bus.poll_req = 1'b1;
    tick();
    bus.poll_req = 1'b0;
  endtask
  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.poll_req = 1'b0;
    bus16.poll_req = 1'b0;
    bus16.pad_data = 1'b0;
    tick(3);
    check("rst_state", 32'(bus.state), 0);
    check("rst_latch", 32'(bus.latch), 0);
    check("rst_pad_clk", 32'(bus.pad_clk), 1);
    check("rst_buttons", 32'(bus.buttons), 0);
    check("rst_pressed", 32'(bus.pressed), 0);
    check("rst_valid", 32'(bus.valid), 0);
    reset = 1'b0;
    mask0 = 8'h09;
    mask1 = 8'h00;
    tick(4);
    poll_start();
    check("poll_to_latch", 32'(bus.state), 1);
    scan(16'h0009, 0, 0);
    // valid cycle itself was the first idle cycle, so 999 remain
    mask1 = 8'h01;
    scan(16'h0109, POLL - 1, 0);
    for (int i = 0; i < 4; i++) begin
      mask0 = 8'($urandom);
      mask1 = 8'($urandom);
      nb = {mask1, mask0};
      if (i % 2 == 1) begin
        tick($urandom_range(1, 50));
        poll_start();
        scan(nb, 0, 0);
      end else scan(nb, POLL - 1, 0);
    end
    mask0 = 8'($urandom);
    mask1 = 8'($urandom);
    nb = {mask1, mask0};
    poll_start();
    scan(nb, 0, 100);
    mask0 = 8'($urandom) | 8'h10;
    nb = {mask1, mask0};
    scan(nb, POLL - 1, 0);
    mask0 = ~mask0;
    mask1 = 8'($urandom);
    poll_start();
    tick(280);
    check("mid_scan_state", 32'(bus.state), 3);
    reset = 1'b1;
    #1;
    check("abort_latch", 32'(bus.latch), 0);
    check("abort_pad_clk", 32'(bus.pad_clk), 1);
    check("abort_buttons", 32'(bus.buttons), 0);
    check("abort_state", 32'(bus.state), 0);
    check("abort_valid", 32'(bus.valid), 0);
    tick(2);
    reset = 1'b0;
    prev_b = '0;
    scan({mask1, mask0}, POLL, 0);
    tick(1000);
    check("w16_scans", 32'(scans16 > 0), 1);
    check("w16_scan_len", 32'(last_busy16), 2 * CLK_DIV + 15 * 2 * CLK_DIV + 1);
    check("w16_pulses", 32'(last_pulses16), 15);
    check("w16_buttons", 32'(last_buttons16), 32'h0000FFFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
